// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, parity codes, width defaults.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_PRESC_W    = 5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts 0..period-1 while enabled and pulses bit_done on the last cycle.
module uart_bit_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         bit_done
);

  logic [W-1:0] count;

  // period is never 0 while enabled, so period-1 cannot wrap
  assign bit_done = enable && (count == period - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_done) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PRESC_W    = UART_PRESC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYPE,
  input  logic [PRESC_W-1:0]    prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  uart_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic [PRESC_W-1:0]    period_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  bit_done;
  logic                  par_bit;

  uart_bit_timer #(.W(PRESC_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .clear    (accept),
    .enable   (state_q != IDLE),
    .period   (period_q),
    .bit_done (bit_done)
  );

  assign par_bit = (^data_q) ^ (par_type_q == PAR_ODD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Data_Valid && !busy_q) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so TX_OUT is a clean register output
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      period_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (accept) begin
        data_q     <= P_DATA;
        par_en_q   <= PAR_EN;
        par_type_q <= PAR_TYPE;
        period_q   <= (prescale == '0) ? PRESC_W'(1) : prescale;
      end
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx with a bit-level frame monitor and mid-bit decoder.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYPE;
  logic [4:0] prescale;
  logic       TX_OUT;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYPE   (PAR_TYPE),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptype, input logic [4:0] ps);
    @(negedge clk);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYPE   = ptype;
    prescale   = ps;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  // Called on the negedge of the first start-bit cycle; returns on the negedge of the idle cycle after stop.
  task automatic observe(input string tag, input logic [7:0] d, input logic pen, input logic pbit, input int p);
    int         nb;
    int         busy_n;
    int         good;
    logic       eb;
    logic [7:0] rx;
    logic       rxp;
    nb     = pen ? 11 : 10;
    busy_n = 0;
    rx     = 8'h00;
    rxp    = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (k == 0)                eb = 1'b0;
      else if (k <= 8)           eb = d[k-1];
      else if (pen && k == 9)    eb = pbit;
      else                       eb = 1'b1;
      good = 0;
      for (int c = 0; c < p; c++) begin
        if (TX_OUT === eb) good++;
        if (busy === 1'b1) busy_n++;
        if (c == p / 2) begin
          if (k >= 1 && k <= 8) rx[k-1] = TX_OUT;
          if (pen && k == 9)    rxp = TX_OUT;
        end
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), good, p);
    end
    chk({tag, "_busy_len"}, busy_n, nb * p);
    chk({tag, "_rx_byte"}, {24'd0, rx}, {24'd0, d});
    if (pen) chk({tag, "_rx_par"}, {31'd0, rxp}, {31'd0, pbit});
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_tx"}, {31'd0, TX_OUT}, 32'd1);
  endtask

  initial begin
    int highs;
    rst        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYPE   = 1'b0;
    prescale   = 5'd16;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 0xA3 LSB first: 1,1,0,0,0,1,0,1 ; four ones -> even parity 0, odd parity 1
    send(8'hA3, 1'b0, 1'b0, 5'd16);
    observe("t1", 8'hA3, 1'b0, 1'b0, 16);
    send(8'hA3, 1'b1, 1'b0, 5'd16);
    observe("t2", 8'hA3, 1'b1, 1'b0, 16);
    send(8'hA3, 1'b1, 1'b1, 5'd8);
    observe("t3", 8'hA3, 1'b1, 1'b1, 8);

    // Request held high through a frame with new data queued behind it
    @(negedge clk);
    P_DATA     = 8'hA3;
    PAR_EN     = 1'b0;
    PAR_TYPE   = 1'b0;
    prescale   = 5'd16;
    Data_Valid = 1'b1;
    @(negedge clk);
    P_DATA = 8'h5C;
    observe("t4a", 8'hA3, 1'b0, 1'b0, 16);
    @(negedge clk);
    Data_Valid = 1'b0;
    observe("t4b", 8'h5C, 1'b0, 1'b0, 16);
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      if (TX_OUT === 1'b1 && busy === 1'b0) highs++;
      @(negedge clk);
    end
    chk("t4_no_third_frame", highs, 40);

    // Reset in data bit 3 (bit3 of 0xA3 is 0, frame cycles 32..39 at P=8)
    send(8'hA3, 1'b0, 1'b0, 5'd8);
    repeat (34) @(negedge clk);
    chk("t5_pre_reset_tx", {31'd0, TX_OUT}, 32'd0);
    chk("t5_pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_tx", {31'd0, TX_OUT}, 32'd1);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(8'hFF, 1'b0, 1'b0, 5'd8);
    observe("t5", 8'hFF, 1'b0, 1'b0, 8);

    // Mid-frame input changes must not disturb the captured frame settings
    send(8'hA3, 1'b1, 1'b0, 5'd16);
    prescale = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYPE = 1'b1;
    P_DATA   = 8'h00;
    observe("t6a", 8'hA3, 1'b1, 1'b0, 16);
    send(8'h3C, 1'b0, 1'b0, 5'd8);
    observe("t6b", 8'h3C, 1'b0, 1'b0, 8);

    // Prescale boundaries: 0 acts as 1, 1, and the 31 maximum
    send(8'h55, 1'b0, 1'b0, 5'd0);
    observe("p0", 8'h55, 1'b0, 1'b0, 1);
    send(8'h81, 1'b1, 1'b1, 5'd1);
    observe("p1", 8'h81, 1'b1, 1'b1, 1);
    send(8'h07, 1'b1, 1'b0, 5'd3);
    observe("p3", 8'h07, 1'b1, 1'b1, 3);
    send(8'h01, 1'b0, 1'b0, 5'd31);
    observe("p31", 8'h01, 1'b0, 1'b0, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
